mem_responder: RTL and testbench
================================

# mem_responder

Word-addressed memory responder for the multi-cycle CPU's memory port. It answers the CPU's level-held `readM`/`writeM` requests over the shared bidirectional `data` bus, with parameterised read and write latency. It adds a `ready` completion strobe so the control FSM can wait on memory instead of assuming fixed timing. It sits between `cpu` and the storage array, replacing the untimed behavioural memory model.

## Interface
- `ADDR_BITS`, 8: index width; depth = 2^ADDR_BITS 16-bit words.
- `READ_LATENCY`, 2: cycles from the request sample to read data valid; minimum 1.
- `WRITE_LATENCY`, 1: cycles from the request sample to write commit; minimum 1.

Ports (one clock, `Clk`; reset `Reset_N` is asynchronous, active-low):
- `Clk`  in  1  system clock; all state updates on the rising edge.
- `Reset_N`  in  1  asynchronous active-low reset.
- `readM`  in  1  read request; the initiator holds it until `ready` is seen.
- `writeM`  in  1  write request; the initiator holds it until `ready` is seen.
- `address`  in  16  word address; only `address[ADDR_BITS-1:0]` is used.
- `data`  inout  16  driven by the initiator for writes; driven by this block only while a read completes.
- `ready`  out  1  transaction complete, high in the DONE states.
- `protocol_err`  out  1  sticky flag, set when `readM` and `writeM` are sampled high together.

## Operation
- FSM states: IDLE, RD_WAIT, RD_DONE, WR_WAIT, WR_DONE.
- Reset:
  - FSM goes to IDLE, `ready`=0, `protocol_err`=0, `data` is hi-Z, latency counter = 0.
  - Array contents are not cleared and are preserved across reset.
- IDLE, `readM`=1 and `writeM`=0 sampled:
  - Latch the address index.
  - Counter = READ_LATENCY-1.
  - Go to RD_WAIT, or directly to RD_DONE when READ_LATENCY=1, loading the read register from the array.
- RD_WAIT:
  - Decrement the counter each cycle.
  - When counter=0 and `readM`=1, load the read register from the array at the latched index and go to RD_DONE.
- RD_DONE:
  - `ready`=1.
  - `data` = read register while `readM`=1; hi-Z as soon as `readM`=0 (combinational release, no bus contention).
  - `readM` sampled 0 -> IDLE.
- IDLE, `writeM`=1 and `readM`=0 sampled:
  - Latch the index and `data`.
  - Counter = WRITE_LATENCY-1.
  - Go to WR_WAIT, or commit and go directly to WR_DONE when WRITE_LATENCY=1.
- WR_WAIT:
  - Decrement the counter.
  - At 0, write the latched data to the array and go to WR_DONE.
- WR_DONE: `ready`=1; `writeM` sampled 0 -> IDLE.
- Abort: the request is sampled low in RD_WAIT or WR_WAIT.
  - Return to IDLE.
  - Nothing is written; `ready` is never asserted; `data` stays hi-Z.
- Both requests sampled high in IDLE:
  - Set `protocol_err`; stay in IDLE; no array access.
  - The flag clears only on reset.
- Address wrap: upper address bits are ignored, so 0x0105 aliases 0x0005 with ADDR_BITS=8.
- Reset mid-transaction:
  - Any pending write is discarded.
  - `ready` and the bus driver drop immediately (asynchronously).
- Write data is captured at the request sample. Changes on `data` during WR_WAIT are ignored.

## Timing
- Request sampled at edge N.
  - Read: `ready` and valid `data` rise after edge N+READ_LATENCY.
  - Write: array updated and `ready` rises after edge N+WRITE_LATENCY.
- `ready` stays high until the edge where the request is sampled low; it falls after that edge.
- Back-to-back transactions:
  - A new request is sampled no earlier than the edge after the DONE->IDLE transition.
  - Minimum gap is one IDLE cycle.
  - Read throughput is one word per READ_LATENCY+2 cycles.
- The array read is synchronous into the read register. `data` output changes only on the `readM` level and on state.

## Test plan
- Reset: hold `Reset_N`=0 with `readM`=1 -> `ready`=0, `data`=Z, `protocol_err`=0; after release, the FSM samples in IDLE on the next edge.
- Write then read (defaults):
  - Write 0x1234 to address 0x0010 -> `ready` high 1 cycle after the sample.
  - Read 0x0010 -> `ready` and `data`=0x1234 two cycles after the sample.
  - `data`=Z in the cycle after `readM` drops.
- Wrap: write 0xBEEF to address 0x0105, then read 0x0005 -> `data`=0xBEEF.
- Abort:
  - Read of 0x0010 with `readM` dropped after 1 cycle -> `ready` never high, `data` stays Z.
  - Write of 0xFFFF to 0x0010 aborted with WRITE_LATENCY=3 -> a later read returns 0x1234.
- Both requests: `readM`=`writeM`=1 with `data`=0xAAAA at address 0x0010.
  - Expect `protocol_err`=1 held, `ready`=0; a later read returns 0x1234.
  - `protocol_err` clears only after a `Reset_N` pulse.
- Reset mid-write: with WRITE_LATENCY=3, write 0x5555 to 0x0010 and pulse `Reset_N` in WR_WAIT.
  - Expect `ready`=0 immediately; a subsequent read returns 0x1234.

Source files
------------

// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : mem_responder
// Brief    : Word-addressed memory responder for the CPU memory port. Answers
//            level-held readM/writeM requests over a shared bidirectional data
//            bus with parameterised read/write latency and a ready strobe.
// Revision : 1.0 - initial release
// ============================================================================
module mem_responder #(
  parameter int ADDR_BITS     = 8,
  parameter int READ_LATENCY  = 2,
  parameter int WRITE_LATENCY = 1
) (
  input  logic        Clk,
  input  logic        Reset_N,
  input  logic        readM,
  input  logic        writeM,
  input  logic [15:0] address,
  inout  wire  [15:0] data,
  output logic        ready,
  output logic        protocol_err
);

  localparam int c_DEPTH   = 1 << ADDR_BITS;
  localparam int c_MAX_LAT = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
  localparam int c_CNT_W   = (c_MAX_LAT > 1) ? $clog2(c_MAX_LAT) : 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_WAIT = 3'd1,
    S_RD_DONE = 3'd2,
    S_WR_WAIT = 3'd3,
    S_WR_DONE = 3'd4
  } state_t;

  state_t                 r_state;
  logic [c_CNT_W-1:0]     r_cnt;
  logic [ADDR_BITS-1:0]   r_idx;
  logic [15:0]            r_wdata;
  logic [15:0]            r_rdata;
  logic                   r_ready;
  logic                   r_perr;
  logic [15:0]            r_mem [c_DEPTH];

  logic [ADDR_BITS-1:0]   w_idx;
  logic                   w_we;
  logic [ADDR_BITS-1:0]   w_waddr;
  logic [15:0]            w_wdata;
  logic                   w_drive;
  logic                   w_unused_addr;

  // Upper address bits are deliberately ignored, so addresses alias modulo depth.
  assign w_idx         = address[ADDR_BITS-1:0];
  assign w_unused_addr = ^address;

  // The bus is driven only while a read completes, and released the moment
  // readM drops so the initiator can take the bus without contention.
  assign w_drive = (r_state == S_RD_DONE) && readM;
  assign data    = w_drive ? r_rdata : 16'hzzzz;

  assign ready        = r_ready;
  assign protocol_err = r_perr;

  // Array write strobe: immediate commit for single-cycle writes, otherwise the
  // latched index/data commit when the wait counter expires. Gated by reset so a
  // request held during reset can never disturb the array.
  always_comb begin
    w_we    = 1'b0;
    w_waddr = r_idx;
    w_wdata = r_wdata;
    if (Reset_N) begin
      case (r_state)
        S_IDLE: begin
          if (writeM && !readM && (WRITE_LATENCY == 1)) begin
            w_we    = 1'b1;
            w_waddr = w_idx;
            w_wdata = data;
          end
        end
        S_WR_WAIT: begin
          if (writeM && (r_cnt == '0)) begin
            w_we = 1'b1;
          end
        end
        default: begin
          w_we = 1'b0;
        end
      endcase
    end
  end

  // Storage array; never reset so contents survive a reset pulse.
  always_ff @(posedge Clk) begin
    if (w_we) begin
      r_mem[w_waddr] <= w_wdata;
    end
  end

  // Transaction FSM with registered ready/protocol_err and synchronous array read.
  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_ready <= 1'b0;
      r_perr  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (readM && writeM) begin
            // Conflicting request: flag it, make no array access.
            r_perr <= 1'b1;
          end else if (readM) begin
            r_idx <= w_idx;
            r_cnt <= c_CNT_W'(READ_LATENCY - 1);
            if (READ_LATENCY == 1) begin
              r_rdata <= r_mem[w_idx];
              r_ready <= 1'b1;
              r_state <= S_RD_DONE;
            end else begin
              r_state <= S_RD_WAIT;
            end
          end else if (writeM) begin
            r_idx   <= w_idx;
            r_wdata <= data;
            r_cnt   <= c_CNT_W'(WRITE_LATENCY - 1);
            if (WRITE_LATENCY == 1) begin
              r_ready <= 1'b1;
              r_state <= S_WR_DONE;
            end else begin
              r_state <= S_WR_WAIT;
            end
          end
        end
        S_RD_WAIT: begin
          if (!readM) begin
            r_state <= S_IDLE;
          end else if (r_cnt == '0) begin
            r_rdata <= r_mem[r_idx];
            r_ready <= 1'b1;
            r_state <= S_RD_DONE;
          end else begin
            r_cnt <= r_cnt - c_CNT_W'(1);
          end
        end
        S_RD_DONE: begin
          if (!readM) begin
            r_ready <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        S_WR_WAIT: begin
          if (!writeM) begin
            r_state <= S_IDLE;
          end else if (r_cnt == '0) begin
            r_ready <= 1'b1;
            r_state <= S_WR_DONE;
          end else begin
            r_cnt <= r_cnt - c_CNT_W'(1);
          end
        end
        S_WR_DONE: begin
          if (!writeM) begin
            r_ready <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_ready <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_responder
// Brief    : Self-checking bench for mem_responder: directed vector table,
//            multi-cycle corner sequences and randomised traffic checked
//            against a word-array reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_responder;

  localparam int TB_AB = 8;
  localparam int TB_RL = 2;
  localparam int TB_WL = 3;

  localparam int OP_WR    = 0;
  localparam int OP_RD    = 1;
  localparam int OP_RDAB  = 2;
  localparam int OP_WRAB  = 3;
  localparam int OP_BOTH  = 4;
  localparam int OP_RSTWR = 5;

  logic        Clk     = 1'b0;
  logic        Reset_N = 1'b0;
  logic        readM   = 1'b0;
  logic        writeM  = 1'b0;
  logic [15:0] address = 16'h0;
  logic        tb_en   = 1'b0;
  logic [15:0] tb_val  = 16'h0;
  wire  [15:0] data;
  logic        ready;
  logic        protocol_err;

  int total = 0;
  int bad   = 0;

  // Reference model: plain word array indexed by the low address bits.
  logic [15:0] m_mem [256];
  bit          m_valid [256];
  bit [7:0]    q_valid [$];
  bit          m_perr = 1'b0;

  typedef struct {
    int          op;
    logic [15:0] addr;
    logic [15:0] wd;
    logic [15:0] exp;
    bit          perr;
  } vec_t;

  vec_t tbl [12];

  assign data = tb_en ? tb_val : 16'hzzzz;

  always #5 Clk = ~Clk;

  mem_responder #(
    .ADDR_BITS     (TB_AB),
    .READ_LATENCY  (TB_RL),
    .WRITE_LATENCY (TB_WL)
  ) dut (
    .Clk          (Clk),
    .Reset_N      (Reset_N),
    .readM        (readM),
    .writeM       (writeM),
    .address      (address),
    .data         (data),
    .ready        (ready),
    .protocol_err (protocol_err)
  );

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Bus released check: the bench pulls the bus to zero; any DUT drive shows up.
  task automatic chk_z(input string nm);
    tb_en  = 1'b1;
    tb_val = 16'h0000;
    #1;
    chk(nm, data, 16'h0000);
    tb_en  = 1'b0;
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_read(input logic [15:0] a, input logic [15:0] exp, input bit chkd);
    address = a;
    tb_en   = 1'b0;
    readM   = 1'b1;
    for (int e = 0; e <= TB_RL; e++) begin
      tick();
      if (e < TB_RL) chk("rd_wait_ready", 16'(ready), 16'd0);
      else           chk("rd_ready", 16'(ready), 16'd1);
    end
    if (chkd) chk("rd_data", data, exp);
    readM = 1'b0;
    chk_z("rd_release_z");
    chk("rd_ready_hold", 16'(ready), 16'd1);
    tick();
    chk("rd_ready_fall", 16'(ready), 16'd0);
  endtask

  task automatic do_write(input logic [15:0] a, input logic [15:0] v);
    address = a;
    tb_en   = 1'b1;
    tb_val  = v;
    writeM  = 1'b1;
    for (int e = 0; e <= TB_WL; e++) begin
      tick();
      if (e == 0) tb_val = ~v;
      if (e < TB_WL) chk("wr_wait_ready", 16'(ready), 16'd0);
      else           chk("wr_ready", 16'(ready), 16'd1);
    end
    writeM = 1'b0;
    tb_en  = 1'b0;
    #1;
    chk("wr_ready_hold", 16'(ready), 16'd1);
    tick();
    chk("wr_ready_fall", 16'(ready), 16'd0);
  endtask

  task automatic do_abort_rd(input logic [15:0] a, input int k);
    address = a;
    readM   = 1'b1;
    for (int e = 0; e < k; e++) begin
      tick();
      chk("rdab_ready", 16'(ready), 16'd0);
    end
    readM = 1'b0;
    for (int e = 0; e < 2; e++) begin
      tick();
      chk("rdab_ready_idle", 16'(ready), 16'd0);
      chk_z("rdab_z");
    end
  endtask

  task automatic do_abort_wr(input logic [15:0] a, input logic [15:0] v, input int k);
    address = a;
    tb_en   = 1'b1;
    tb_val  = v;
    writeM  = 1'b1;
    for (int e = 0; e < k; e++) begin
      tick();
      chk("wrab_ready", 16'(ready), 16'd0);
    end
    writeM = 1'b0;
    tb_en  = 1'b0;
    for (int e = 0; e < 2; e++) begin
      tick();
      chk("wrab_ready_idle", 16'(ready), 16'd0);
    end
  endtask

  task automatic do_both(input logic [15:0] a, input logic [15:0] v);
    address = a;
    tb_en   = 1'b1;
    tb_val  = v;
    readM   = 1'b1;
    writeM  = 1'b1;
    for (int e = 0; e < 3; e++) begin
      tick();
      chk("both_perr", 16'(protocol_err), 16'd1);
      chk("both_ready", 16'(ready), 16'd0);
    end
    readM  = 1'b0;
    writeM = 1'b0;
    tb_en  = 1'b0;
    tick();
    chk("both_perr_sticky", 16'(protocol_err), 16'd1);
  endtask

  task automatic do_rst_wr(input logic [15:0] a, input logic [15:0] v);
    address = a;
    tb_en   = 1'b1;
    tb_val  = v;
    writeM  = 1'b1;
    tick();
    tick();
    Reset_N = 1'b0;
    #1;
    chk("rstwr_ready", 16'(ready), 16'd0);
    chk("rstwr_perr", 16'(protocol_err), 16'd0);
    writeM = 1'b0;
    tb_en  = 1'b0;
    tick();
    Reset_N = 1'b1;
    tick();
    chk("rstwr_ready_after", 16'(ready), 16'd0);
  endtask

  // Runs one operation and keeps the reference model in step with it.
  task automatic run_op(input int op, input logic [15:0] a, input logic [15:0] wd,
                        input logic [15:0] exp, input bit chkd, input int k);
    case (op)
      OP_WR: begin
        do_write(a, wd);
        if (!m_valid[a[7:0]]) q_valid.push_back(a[7:0]);
        m_mem[a[7:0]]   = wd;
        m_valid[a[7:0]] = 1'b1;
      end
      OP_RD:    do_read(a, exp, chkd);
      OP_RDAB:  do_abort_rd(a, k);
      OP_WRAB:  do_abort_wr(a, wd, k);
      OP_BOTH: begin
        do_both(a, wd);
        m_perr = 1'b1;
      end
      OP_RSTWR: begin
        do_rst_wr(a, wd);
        m_perr = 1'b0;
      end
      default: ;
    endcase
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] a;
    logic [15:0] v;
    int          op;
    bit [7:0]    idx;

    tbl[0]  = '{OP_WR,    16'h0010, 16'h1234, 16'h0000, 1'b0};
    tbl[1]  = '{OP_RD,    16'h0010, 16'h0000, 16'h1234, 1'b0};
    tbl[2]  = '{OP_WR,    16'h0105, 16'hBEEF, 16'h0000, 1'b0};
    tbl[3]  = '{OP_RD,    16'h0005, 16'h0000, 16'hBEEF, 1'b0};
    tbl[4]  = '{OP_RDAB,  16'h0010, 16'h0000, 16'h0000, 1'b0};
    tbl[5]  = '{OP_WRAB,  16'h0010, 16'hFFFF, 16'h0000, 1'b0};
    tbl[6]  = '{OP_RD,    16'h0010, 16'h0000, 16'h1234, 1'b0};
    tbl[7]  = '{OP_BOTH,  16'h0010, 16'hAAAA, 16'h0000, 1'b1};
    tbl[8]  = '{OP_RD,    16'h0010, 16'h0000, 16'h1234, 1'b1};
    tbl[9]  = '{OP_RSTWR, 16'h0010, 16'h5555, 16'h0000, 1'b0};
    tbl[10] = '{OP_RD,    16'h0010, 16'h0000, 16'h1234, 1'b0};
    tbl[11] = '{OP_RD,    16'hFF05, 16'h0000, 16'hBEEF, 1'b0};

    for (int i = 0; i < 256; i++) m_valid[i] = 1'b0;

    // Reset held with a read request pending: nothing may respond.
    Reset_N = 1'b0;
    readM   = 1'b1;
    address = 16'h0010;
    repeat (3) tick();
    chk("reset_ready", 16'(ready), 16'd0);
    chk("reset_perr", 16'(protocol_err), 16'd0);
    chk_z("reset_z");
    tick();
    Reset_N = 1'b1;
    // First edge after release samples the still-held read in IDLE.
    do_read(16'h0010, 16'h0000, 1'b0);

    // Directed vectors.
    for (int i = 0; i < 12; i++) begin
      run_op(tbl[i].op, tbl[i].addr, tbl[i].wd, tbl[i].exp, 1'b1, 1);
      chk("vec_perr", 16'(protocol_err), 16'(tbl[i].perr));
    end

    // Asynchronous reset while a read is completing drops ready and the bus at once.
    address = 16'h0010;
    readM   = 1'b1;
    repeat (TB_RL + 1) tick();
    chk("rddone_ready", 16'(ready), 16'd1);
    chk("rddone_data", data, 16'h1234);
    #2;
    Reset_N = 1'b0;
    #1;
    chk("rddone_rst_ready", 16'(ready), 16'd0);
    chk_z("rddone_rst_z");
    readM = 1'b0;
    tick();
    Reset_N = 1'b1;
    tick();

    // Back-to-back reads with the minimum one-cycle IDLE gap.
    do_read(16'h0005, 16'hBEEF, 1'b1);
    do_read(16'h0010, 16'h1234, 1'b1);

    // Randomised traffic against the reference model.
    for (int n = 0; n < 40; n++) begin
      op = int'($urandom_range(0, 3));
      if ((op == OP_RD) && (q_valid.size() == 0)) op = OP_WR;
      v = 16'($urandom);
      if (op == OP_RD) begin
        idx = q_valid[$urandom_range(0, q_valid.size() - 1)];
        a   = {8'($urandom), idx};
        run_op(OP_RD, a, 16'h0, m_mem[idx], 1'b1, 1);
      end else if (op == OP_RDAB) begin
        a = 16'($urandom);
        run_op(OP_RDAB, a, v, 16'h0, 1'b0, int'($urandom_range(1, TB_RL)));
      end else if (op == OP_WRAB) begin
        a = 16'($urandom);
        run_op(OP_WRAB, a, v, 16'h0, 1'b0, int'($urandom_range(1, TB_WL)));
      end else begin
        a = 16'($urandom);
        run_op(OP_WR, a, v, 16'h0, 1'b0, 1);
      end
      chk("rand_perr", 16'(protocol_err), 16'(m_perr));
    end

    // Final sweep: every written word still matches the model.
    foreach (q_valid[j]) begin
      idx = q_valid[j];
      do_read({8'h00, idx}, m_mem[idx], 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
